// File: rtl/booth_pkg.sv
// Shared command codes, Booth recoding types and recoding helpers for booth_mult.
package booth_pkg;

    localparam logic [2:0] CMD_NOP    = 3'b000;
    localparam logic [2:0] CMD_INIT   = 3'b001;
    localparam logic [2:0] CMD_LOAD_Q = 3'b010;
    localparam logic [2:0] CMD_LOAD_M = 3'b011;
    localparam logic [2:0] CMD_RUN    = 3'b100;
    localparam logic [2:0] CMD_RD_HI  = 3'b101;
    localparam logic [2:0] CMD_RD_LO  = 3'b110;

    typedef enum logic [2:0] {
        SEL_ZERO,
        SEL_ADD_M,
        SEL_SUB_M,
        SEL_ADD_2M,
        SEL_SUB_2M
    } booth_sel_e;

    typedef enum logic {
        ST_IDLE,
        ST_RUN
    } state_e;

    // Radix-2 recoding of {Q[0], Qm1}.
    function automatic booth_sel_e booth_recode2(input logic [1:0] bits);
        case (bits)
            2'b01:   return SEL_ADD_M;
            2'b10:   return SEL_SUB_M;
            default: return SEL_ZERO;
        endcase
    endfunction

    // Radix-4 (modified Booth) recoding of {Q[1], Q[0], Qm1}.
    function automatic booth_sel_e booth_recode4(input logic [2:0] bits);
        case (bits)
            3'b001, 3'b010: return SEL_ADD_M;
            3'b011:         return SEL_ADD_2M;
            3'b100:         return SEL_SUB_2M;
            3'b101, 3'b110: return SEL_SUB_M;
            default:        return SEL_ZERO;
        endcase
    endfunction

endpackage

// File: rtl/booth_step.sv
// One Booth iteration: recode, add/subtract, arithmetic shift of {A,Q,Qm1}.
// BOOTH_RADIX4_EN selects the two-bits-per-step modified Booth variant.
module booth_step
    import booth_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] q,
    input  logic             qm1,
    input  logic [WIDTH-1:0] m,
    output logic [WIDTH-1:0] a_next,
    output logic [WIDTH-1:0] q_next,
    output logic             qm1_next
);

`ifdef BOOTH_RADIX4_EN
    localparam int AW = WIDTH + 2;

    booth_sel_e    sel;
    logic [AW-1:0] a_ext;
    logic [AW-1:0] m_ext;
    logic [AW-1:0] m2_ext;
    logic [AW-1:0] sum;

    // NOTE: every output of a combinational block is given a value before any branch, so no latch is inferred.
    always_comb begin
        sel    = booth_recode4({q[1:0], qm1});
        a_ext  = {{2{a[WIDTH-1]}}, a};
        m_ext  = {{2{m[WIDTH-1]}}, m};
        m2_ext = {m_ext[AW-2:0], 1'b0};
        sum    = a_ext;
        case (sel)
            SEL_ADD_M:  sum = a_ext + m_ext;
            SEL_SUB_M:  sum = a_ext - m_ext;
            SEL_ADD_2M: sum = a_ext + m2_ext;
            SEL_SUB_2M: sum = a_ext - m2_ext;
            default:    sum = a_ext;
        endcase
        // Two guard bits hold the true sign of A +/- 2M, so the shift is exact.
        a_next   = sum[AW-1:2];
        q_next   = {sum[1:0], q[WIDTH-1:2]};
        qm1_next = q[1];
    end
`else
    localparam int AW = WIDTH + 1;

    booth_sel_e    sel;
    logic [AW-1:0] a_ext;
    logic [AW-1:0] m_ext;
    logic [AW-1:0] sum;

    // NOTE: every output of a combinational block is given a value before any branch, so no latch is inferred.
    always_comb begin
        sel   = booth_recode2({q[0], qm1});
        a_ext = {a[WIDTH-1], a};
        m_ext = {m[WIDTH-1], m};
        sum   = a_ext;
        case (sel)
            SEL_ADD_M: sum = a_ext + m_ext;
            SEL_SUB_M: sum = a_ext - m_ext;
            default:   sum = a_ext;
        endcase
        // The extra bit keeps the real sign when A - M overflows (M = -2^(WIDTH-1)).
        a_next   = sum[AW-1:1];
        q_next   = {sum[0], q[WIDTH-1:1]};
        qm1_next = q[0];
    end
`endif

endmodule

// File: rtl/booth_mult.sv
// Sequential signed Booth multiplier with command bus; radix-2 by default,
// radix-4 when BOOTH_RADIX4_EN is defined.
module booth_mult
    import booth_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [2:0]       enable,
    input  logic [WIDTH-1:0] inbus,
    output logic [WIDTH-1:0] outbus,
    output logic             busy
);

    localparam int CW = $clog2(WIDTH + 1);

`ifdef BOOTH_RADIX4_EN
    localparam logic [CW-1:0] ITERS = CW'(WIDTH / 2);
    if (WIDTH % 2 != 0) begin : g_odd_width
        $error("booth_mult: radix-4 mode needs an even WIDTH");
    end
`else
    localparam logic [CW-1:0] ITERS = CW'(WIDTH);
`endif

    if (WIDTH < 2) begin : g_small_width
        $error("booth_mult: WIDTH must be at least 2");
    end

    state_e           state, state_nxt;
    logic [WIDTH-1:0] m_r, m_nxt;
    logic [WIDTH-1:0] a_r, a_nxt;
    logic [WIDTH-1:0] q_r, q_nxt;
    logic             qm1_r, qm1_nxt;
    logic [CW-1:0]    cnt_r, cnt_nxt;

    logic [WIDTH-1:0] step_a, step_q;
    logic             step_qm1;

    booth_step #(.WIDTH(WIDTH)) u_step (
        .a        (a_r),
        .q        (q_r),
        .qm1      (qm1_r),
        .m        (m_r),
        .a_next   (step_a),
        .q_next   (step_q),
        .qm1_next (step_qm1)
    );

    // NOTE: sequential state uses non-blocking assignments so all registers update together at the edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
            m_r   <= '0;
            a_r   <= '0;
            q_r   <= '0;
            qm1_r <= 1'b0;
            cnt_r <= '0;
        end else begin
            state <= state_nxt;
            m_r   <= m_nxt;
            a_r   <= a_nxt;
            q_r   <= q_nxt;
            qm1_r <= qm1_nxt;
            cnt_r <= cnt_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        m_nxt     = m_r;
        a_nxt     = a_r;
        q_nxt     = q_r;
        qm1_nxt   = qm1_r;
        cnt_nxt   = cnt_r;
        if (state == ST_RUN) begin
            // Only init is honoured mid-run; it doubles as the abort.
            if (enable == CMD_INIT) begin
                state_nxt = ST_IDLE;
                m_nxt     = '0;
                a_nxt     = '0;
                q_nxt     = '0;
                qm1_nxt   = 1'b0;
                cnt_nxt   = '0;
            end else begin
                a_nxt   = step_a;
                q_nxt   = step_q;
                qm1_nxt = step_qm1;
                cnt_nxt = cnt_r - CW'(1);
                if (cnt_r == CW'(1)) begin
                    state_nxt = ST_IDLE;
                end
            end
        end else begin
            case (enable)
                CMD_INIT: begin
                    m_nxt   = '0;
                    a_nxt   = '0;
                    q_nxt   = '0;
                    qm1_nxt = 1'b0;
                    cnt_nxt = '0;
                end
                CMD_LOAD_M: m_nxt = inbus;
                CMD_LOAD_Q: begin
                    q_nxt   = inbus;
                    a_nxt   = '0;
                    qm1_nxt = 1'b0;
                end
                CMD_RUN: begin
                    cnt_nxt   = ITERS;
                    state_nxt = ST_RUN;
                end
                default: ;
            endcase
        end
    end

    assign busy = (state == ST_RUN);

    always_comb begin
        case (enable)
            CMD_RD_HI: outbus = a_r;
            CMD_RD_LO: outbus = q_r;
            default:   outbus = '0;
        endcase
    end

endmodule

// File: tb/tb_booth_mult.sv
// Self-checking bench for booth_mult: directed corner products, abort/reset
// mid-run, and randomized signed operands against an arithmetic product model.
module tb_booth_mult;
    import booth_pkg::*;

    localparam int W = 8;
`ifdef BOOTH_RADIX4_EN
    localparam int LAT = W / 2;
`else
    localparam int LAT = W;
`endif

    logic         clk = 1'b0;
    logic         rst_n;
    logic [2:0]   enable;
    logic [W-1:0] inbus;
    logic [W-1:0] outbus;
    logic         busy;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    booth_mult #(.WIDTH(W)) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .enable (enable),
        .inbus  (inbus),
        .outbus (outbus),
        .busy   (busy)
    );

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic logic [2*W-1:0] model_product(input logic [W-1:0] m, input logic [W-1:0] q);
        int ms;
        int qs;
        int p;
        ms = $signed(m);
        qs = $signed(q);
        p  = ms * qs;
        return p[2*W-1:0];
    endfunction

    function automatic logic [W-1:0] rand_operand();
        logic [W-1:0] v;
        case ($urandom_range(0, 7))
            0:       v = 8'h80;
            1:       v = 8'h7F;
            2:       v = 8'hFF;
            default: v = W'($urandom);
        endcase
        return v;
    endfunction

    // Called at a falling edge: drive, let one rising edge sample, return at the next falling edge.
    task automatic issue(input logic [2:0] c, input logic [W-1:0] d);
        enable = c;
        inbus  = d;
        @(negedge clk);
    endtask

    task automatic read_out(output logic [W-1:0] hi, output logic [W-1:0] lo);
        enable = CMD_RD_HI;
        #1 hi = outbus;
        enable = CMD_RD_LO;
        #1 lo = outbus;
        enable = CMD_NOP;
        #1;
    endtask

    task automatic run_wait(input logic [2:0] hold_cmd, output int cycles);
        issue(CMD_RUN, '0);
        enable = hold_cmd;
        cycles = 0;
        while (busy && cycles < 4 * W) begin
            @(negedge clk);
            cycles++;
        end
        enable = CMD_NOP;
    endtask

    task automatic multiply(input logic [W-1:0] m, input logic [W-1:0] q, input logic [2:0] hold_cmd,
                            output logic [W-1:0] hi, output logic [W-1:0] lo, output int cycles);
        issue(CMD_INIT, '0);
        issue(CMD_LOAD_M, m);
        issue(CMD_LOAD_Q, q);
        run_wait(hold_cmd, cycles);
        read_out(hi, lo);
    endtask

    task automatic test_reset();
        rst_n  = 1'b0;
        enable = CMD_NOP;
        inbus  = '0;
        #1;
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL reset_busy: got %b expected 0", busy);
        end
        enable = CMD_RD_HI;
        #1;
        checks++;
        if (outbus !== '0) begin
            errors++;
            $display("FAIL reset_hi: got %h expected 00", outbus);
        end
        enable = CMD_RD_LO;
        #1;
        checks++;
        if (outbus !== '0) begin
            errors++;
            $display("FAIL reset_lo: got %h expected 00", outbus);
        end
        enable = CMD_NOP;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_directed();
        logic [W-1:0] tm   [5] = '{8'h11, 8'hFB, 8'h80, 8'h7F, 8'h00};
        logic [W-1:0] tq   [5] = '{8'h03, 8'h07, 8'h80, 8'h80, 8'h5A};
        logic [W-1:0] ehi  [5] = '{8'h00, 8'hFF, 8'h40, 8'hC0, 8'h00};
        logic [W-1:0] elo  [5] = '{8'h33, 8'hDD, 8'h00, 8'h80, 8'h00};
        logic [W-1:0] hi, lo;
        int           cyc;
        for (int i = 0; i < 5; i++) begin
            multiply(tm[i], tq[i], CMD_NOP, hi, lo, cyc);
            checks++;
            if (hi !== ehi[i]) begin
                errors++;
                $display("FAIL directed_hi[%0d]: got %h expected %h", i, hi, ehi[i]);
            end
            checks++;
            if (lo !== elo[i]) begin
                errors++;
                $display("FAIL directed_lo[%0d]: got %h expected %h", i, lo, elo[i]);
            end
            checks++;
            if (cyc != LAT) begin
                errors++;
                $display("FAIL directed_busy[%0d]: got %0d cycles expected %0d", i, cyc, LAT);
            end
        end
    endtask

    task automatic test_idle_readout();
        logic [W-1:0] hi, lo;
        int           cyc;
        multiply(8'hFB, 8'h07, CMD_NOP, hi, lo, cyc);
        enable = CMD_NOP;
        #1;
        checks++;
        if (outbus !== '0) begin
            errors++;
            $display("FAIL readout_000: got %h expected 00", outbus);
        end
        enable = 3'b111;
        #1;
        checks++;
        if (outbus !== '0) begin
            errors++;
            $display("FAIL readout_111: got %h expected 00", outbus);
        end
        enable = CMD_NOP;
        @(negedge clk);
    endtask

    task automatic test_hold_run();
        logic [W-1:0]   m, q, hi, lo;
        logic [2*W-1:0] exp_p;
        int             cyc;
        m = 8'h93;
        q = 8'h6C;
        exp_p = model_product(m, q);
        multiply(m, q, CMD_RUN, hi, lo, cyc);
        checks++;
        if (cyc != LAT) begin
            errors++;
            $display("FAIL hold_run_busy: got %0d cycles expected %0d", cyc, LAT);
        end
        checks++;
        if ({hi, lo} !== exp_p) begin
            errors++;
            $display("FAIL hold_run_product: got %h expected %h", {hi, lo}, exp_p);
        end
    endtask

    task automatic test_abort();
        logic [W-1:0] hi, lo;
        int           cyc;
        issue(CMD_INIT, '0);
        issue(CMD_LOAD_M, 8'h11);
        issue(CMD_LOAD_Q, 8'h03);
        issue(CMD_RUN, '0);
        enable = CMD_NOP;
        @(negedge clk);
        @(negedge clk);
        checks++;
        if (busy !== 1'b1) begin
            errors++;
            $display("FAIL abort_busy_before: got %b expected 1", busy);
        end
        issue(CMD_INIT, '0);
        enable = CMD_NOP;
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL abort_busy_after: got %b expected 0", busy);
        end
        read_out(hi, lo);
        checks++;
        if ({hi, lo} !== '0) begin
            errors++;
            $display("FAIL abort_regs: got %h expected 0000", {hi, lo});
        end
        // M was cleared by the abort, so a fresh Q must multiply to zero.
        issue(CMD_LOAD_Q, 8'h25);
        run_wait(CMD_NOP, cyc);
        read_out(hi, lo);
        checks++;
        if ({hi, lo} !== '0) begin
            errors++;
            $display("FAIL abort_m_cleared: got %h expected 0000", {hi, lo});
        end
    endtask

    task automatic test_reset_mid_run();
        logic [W-1:0]   hi, lo;
        logic [2*W-1:0] exp_p;
        int             cyc;
        issue(CMD_INIT, '0);
        issue(CMD_LOAD_M, 8'h7F);
        issue(CMD_LOAD_Q, 8'h80);
        issue(CMD_RUN, '0);
        enable = CMD_NOP;
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL midreset_busy: got %b expected 0", busy);
        end
        enable = CMD_RD_LO;
        #1;
        checks++;
        if (outbus !== '0) begin
            errors++;
            $display("FAIL midreset_lo: got %h expected 00", outbus);
        end
        enable = CMD_NOP;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        exp_p = model_product(8'hC5, 8'h3B);
        multiply(8'hC5, 8'h3B, CMD_NOP, hi, lo, cyc);
        checks++;
        if ({hi, lo} !== exp_p) begin
            errors++;
            $display("FAIL midreset_rerun: got %h expected %h", {hi, lo}, exp_p);
        end
    endtask

    task automatic test_random();
        logic [W-1:0]   m, q, hi, lo;
        logic [2*W-1:0] exp_p;
        int             cyc;
        for (int i = 0; i < 1000; i++) begin
            m = rand_operand();
            q = rand_operand();
            exp_p = model_product(m, q);
            multiply(m, q, CMD_NOP, hi, lo, cyc);
            checks++;
            if ({hi, lo} !== exp_p) begin
                errors++;
                $display("FAIL random_product[%0d]: %h*%h got %h expected %h", i, m, q, {hi, lo}, exp_p);
            end
            checks++;
            if (cyc != LAT) begin
                errors++;
                $display("FAIL random_busy[%0d]: got %0d cycles expected %0d", i, cyc, LAT);
            end
        end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_idle_readout();
        test_hold_run();
        test_abort();
        test_reset_mid_run();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
